humming_stream_ctrl: RTL

HUMMING_STREAM_CTRL -- requirements
Module: humming_stream_ctrl

---
 rtl/humming_pkg.sv | 15 +
 rtl/humming_sync_fifo.sv | 45 ++++
 rtl/humming_stream_ctrl.sv | 136 +++++++++++++
 3 files changed

// File: rtl/humming_pkg.sv
// Shared FSM state and cipher-mode encodings for the humming stream controller.
package humming_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INIT,
    ST_STREAM,
    ST_WAIT_CORE,
    ST_FINISH
  } state_t;

  localparam logic MODE_ENC = 1'b0;
  localparam logic MODE_DEC = 1'b1;

endpackage

// File: rtl/humming_sync_fifo.sv
// Synchronous FIFO with a combinational head; push/pop land on the clock edge and are legal together.
// A push while full is dropped, a pop while empty is ignored, and flush empties it in one cycle (over a push).
module humming_sync_fifo #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              empty,
  output logic              full
);
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  // Pointers carry one wrap bit so full and empty are distinguishable.
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/humming_stream_ctrl.sv
// Session controller feeding a one-word-in-flight cipher core from an input FIFO; core_load issues combinationally off the FIFO head.
// Backpressure: in_ready drops while the FIFO is full or on abort; a held out_valid stalls issue until out_ready.
module humming_stream_ctrl
  import humming_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int FIFO_DEPTH  = 4,
  parameter int INIT_CYCLES = 4,
  parameter int LEN_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              mode,
  input  logic [LEN_W-1:0]  sess_len,
  input  logic [DATA_W-1:0] nonce0,
  input  logic [DATA_W-1:0] nonce1,
  input  logic [DATA_W-1:0] nonce2,
  input  logic [DATA_W-1:0] nonce3,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              core_init,
  output logic              core_mode,
  output logic              core_load,
  output logic [DATA_W-1:0] core_din,
  input  logic [DATA_W-1:0] core_dout,
  input  logic              core_done,
  output logic              busy,
  output logic              sess_done,
  output logic [LEN_W-1:0]  word_cnt
);
  localparam int CW = $clog2(INIT_CYCLES + 1);

  state_t            state, state_nxt;
  logic [CW-1:0]     init_cnt;
  logic [LEN_W-1:0]  len_q, issue_cnt;
  logic [DATA_W-1:0] nonce_sum, fifo_head;
  logic              mode_q;
  logic              fifo_empty, fifo_full, fifo_push, fifo_flush;
  logic              out_hs, last_hs, init_last, issue, launch;
  logic              unused_nonce;

  // Only nonce0 and nonce2 feed the core's init word.
  assign unused_nonce = ^{nonce1, nonce3};

  assign busy       = (state != ST_IDLE);
  assign launch     = (state == ST_IDLE) && start && !abort;
  assign in_ready   = busy & ~fifo_full & ~abort;
  assign fifo_push  = in_valid & in_ready;
  assign fifo_flush = (busy & abort) | (state == ST_FINISH);
  assign out_hs     = out_valid & out_ready;
  assign last_hs    = out_hs && ((word_cnt + LEN_W'(1)) == len_q);
  assign init_last  = (init_cnt == CW'(INIT_CYCLES - 1));
  // Issue only into an output slot that is empty or draining this cycle, and never past sess_len.
  assign issue      = (state == ST_STREAM) && !abort && !fifo_empty &&
                      (issue_cnt < len_q) && (!out_valid || out_ready);

  assign core_init  = (state == ST_INIT);
  assign core_load  = issue;
  assign core_din   = core_init ? nonce_sum : (issue ? fifo_head : '0);
  assign core_mode  = mode_q;
  assign sess_done  = (state == ST_FINISH) && !abort;

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:      if (launch) state_nxt = ST_INIT;
      ST_INIT:      if (init_last) state_nxt = (len_q == '0) ? ST_FINISH : ST_STREAM;
      ST_STREAM: begin
        if (last_hs)    state_nxt = ST_FINISH;
        else if (issue) state_nxt = ST_WAIT_CORE;
      end
      ST_WAIT_CORE: if (core_done) state_nxt = ST_STREAM;
      ST_FINISH:    state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
    if (busy && abort) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      init_cnt  <= '0;
      len_q     <= '0;
      issue_cnt <= '0;
      nonce_sum <= '0;
      mode_q    <= MODE_ENC;
      word_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      state    <= state_nxt;
      init_cnt <= core_init ? init_cnt + CW'(1) : '0;
      if (launch) begin
        mode_q    <= mode;
        len_q     <= sess_len;
        nonce_sum <= nonce0 + nonce2;
        issue_cnt <= '0;
        word_cnt  <= '0;
      end else begin
        if (issue)  issue_cnt <= issue_cnt + LEN_W'(1);
        if (out_hs) word_cnt  <= word_cnt + LEN_W'(1);
      end
      // A core_done outside WAIT_CORE (e.g. after abort) is dropped here.
      if (busy && abort) begin
        out_valid <= 1'b0;
      end else if ((state == ST_WAIT_CORE) && core_done) begin
        out_valid <= 1'b1;
        out_data  <= core_dout;
      end else if (out_hs) begin
        out_valid <= 1'b0;
      end
    end
  end

  humming_sync_fifo #(
    .DATA_W    (DATA_W),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .flush    (fifo_flush),
    .push     (fifo_push),
    .push_data(in_data),
    .pop      (issue),
    .head     (fifo_head),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

endmodule
